// File: rtl/arbitro_pkg.sv
// Shared types and helpers for the round-robin FIFO-to-FIFO arbiter.
package arbitro_pkg;

    localparam int DEF_NUM_CH  = 4;
    localparam int DEF_DATA_W  = 12;
    localparam int DEF_QUANTUM = 4;
    localparam int DEF_CNT_W   = 16;
    localparam int WORD_MAX_W  = 64;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) res = i + 1;
        end
        return res;
    endfunction

    // Destination lives in the top dest_w bits of a data_w-bit word.
    function automatic logic [31:0] dest_field(input logic [WORD_MAX_W-1:0] word,
                                               input int data_w,
                                               input int dest_w);
        logic [WORD_MAX_W-1:0] shifted;
        shifted = word >> (data_w - dest_w);
        return shifted[31:0] & ((32'd1 << dest_w) - 32'd1);
    endfunction

endpackage

// File: rtl/arbitro_rr_param_rr_pick.sv
// Combinational round-robin search: first set request at or after start, wrapping.
module rr_pick #(
    parameter int NUM_CH = 4,
    parameter int IDX_W  = 2
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [IDX_W-1:0]  start,
    output logic              found,
    output logic [IDX_W-1:0]  idx
);

    logic [IDX_W-1:0] cand;

    // NUM_CH is a power of two, so IDX_W-bit addition wraps naturally.
    always_comb begin
        found = 1'b0;
        idx   = start;
        cand  = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            cand = start + IDX_W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/arbitro_rr_param.sv
// Round-robin arbiter draining NUM_CH show-ahead FIFOs into NUM_CH output FIFOs.
// Optional statistics counters are built when ARB_STATS_EN is defined.
//
//   state | meaning
//   IDLE  | search for next non-empty channel after grant, no pop
//   SERVE | pop granted channel up to QUANTUM words, stall on almost_full
module arbitro_rr_param
    import arbitro_pkg::*;
#(
    parameter int NUM_CH  = DEF_NUM_CH,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int DEST_W  = clog2(NUM_CH),
    parameter int QUANTUM = DEF_QUANTUM,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH*DATA_W-1:0]   in_data,
    input  logic [NUM_CH-1:0]          in_empty,
    output logic [NUM_CH-1:0]          in_pop,
    input  logic [NUM_CH-1:0]          out_almost_full,
    output logic [NUM_CH-1:0]          out_push,
    output logic [DATA_W-1:0]          out_data,
    output logic [clog2(NUM_CH)-1:0]   grant,
`ifdef ARB_STATS_EN
    output logic [NUM_CH*CNT_W-1:0]    stats_words,
    output logic [CNT_W-1:0]           stats_stall,
`endif
    output logic                       busy
);

    localparam int GW = clog2(NUM_CH);
    localparam int CW = clog2(QUANTUM + 1);

    state_t          state, state_nxt;
    logic [GW-1:0]   grant_nxt;
    logic [CW-1:0]   count, count_nxt;
    logic [DATA_W-1:0] head;
    logic [DEST_W-1:0] dest;
    logic            pop_en;
    logic            pick_found;
    logic [GW-1:0]   pick_idx;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .IDX_W  (GW)
    ) u_rr_pick (
        .req    (~in_empty),
        .start  (grant + GW'(1)),
        .found  (pick_found),
        .idx    (pick_idx)
    );

    always_comb begin
        head   = in_data[grant*DATA_W +: DATA_W];
        dest   = DEST_W'(dest_field(WORD_MAX_W'(head), DATA_W, DEST_W));
        pop_en = (state == SERVE) && !in_empty[grant] && !out_almost_full[dest]
                 && (count < CW'(QUANTUM));
        in_pop = '0;
        if (pop_en) in_pop[grant] = 1'b1;
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        count_nxt = count;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    grant_nxt = pick_idx;
                    count_nxt = '0;
                    state_nxt = SERVE;
                end
            end
            SERVE: begin
                if (pop_en) count_nxt = count + CW'(1);
                // Quantum is judged on the post-increment count, so both exit causes merge here.
                if (in_empty[grant] || (count_nxt == CW'(QUANTUM))) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            grant    <= GW'(NUM_CH - 1);
            count    <= '0;
            out_push <= '0;
            out_data <= '0;
        end else begin
            state    <= state_nxt;
            grant    <= grant_nxt;
            count    <= count_nxt;
            out_push <= '0;
            if (pop_en) begin
                out_push[dest] <= 1'b1;
                out_data       <= head;
            end
        end
    end

    assign busy = (state == SERVE);

`ifdef ARB_STATS_EN
    logic [NUM_CH-1:0][CNT_W-1:0] words_q;
    logic [CNT_W-1:0]             stall_q;
    logic                         stall_now;

    assign stall_now   = (state == SERVE) && !in_empty[grant] && out_almost_full[dest]
                         && (count < CW'(QUANTUM));
    assign stats_words = words_q;
    assign stats_stall = stall_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            words_q <= '0;
            stall_q <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (out_push[i] && (words_q[i] != '1)) words_q[i] <= words_q[i] + CNT_W'(1);
            end
            if (stall_now && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_arbitro_rr_param.sv
// Scoreboard bench for arbitro_rr_param: FIFO models, abstract round-robin order model, push monitor.
module tb_arbitro_rr_param;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int Q  = 4;
    localparam int CW = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic [N*DW-1:0]   in_data;
    logic [N-1:0]      in_empty;
    logic [N-1:0]      in_pop;
    logic [N-1:0]      out_almost_full;
    logic [N-1:0]      out_push;
    logic [DW-1:0]     out_data;
    logic [1:0]        grant;
    logic              busy;
`ifdef ARB_STATS_EN
    logic [N*CW-1:0]   stats_words;
    logic [CW-1:0]     stats_stall;
`endif

    arbitro_rr_param #(.NUM_CH(N), .DATA_W(DW), .QUANTUM(Q), .CNT_W(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_data         (in_data),
        .in_empty        (in_empty),
        .in_pop          (in_pop),
        .out_almost_full (out_almost_full),
        .out_push        (out_push),
        .out_data        (out_data),
        .grant           (grant),
`ifdef ARB_STATS_EN
        .stats_words     (stats_words),
        .stats_stall     (stats_stall),
`endif
        .busy            (busy)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] in_q [N][$];
    logic [DW-1:0] exp_q [$];
    int            pop_cyc [$];
    int            pop_ch [$];
    int            n_checks = 0;
    int            n_fail = 0;
    int            cyc = 0;
    int            model_last = N - 1;
    bit            rand_af = 1'b0;
    bit            prev_pop = 1'b0;

    function automatic int dest_of(input logic [DW-1:0] w);
        return int'(w[DW-1 -: 2]);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic refresh();
        for (int ch = 0; ch < N; ch++) begin
            in_empty[ch] = (in_q[ch].size() == 0);
            in_data[ch*DW +: DW] = (in_q[ch].size() == 0) ? '0 : in_q[ch][0];
        end
    endtask

    // Expected output order: visit channels round-robin after the last served
    // one, taking up to Q words from each non-empty queue, until all are drained.
    task automatic build_expected();
        int pos [N];
        int ptr;
        bit any;
        for (int ch = 0; ch < N; ch++) pos[ch] = 0;
        ptr = model_last;
        do begin
            any = 1'b0;
            for (int k = 1; k <= N; k++) begin
                int ch;
                ch = (ptr + k) % N;
                if (!any && pos[ch] < in_q[ch].size()) begin
                    for (int j = 0; j < Q && pos[ch] < in_q[ch].size(); j++) begin
                        exp_q.push_back(in_q[ch][pos[ch]]);
                        pos[ch]++;
                    end
                    ptr = ch;
                    any = 1'b1;
                end
            end
        end while (any);
        model_last = ptr;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        step(1);
        reset = 1'b0;
        exp_q.delete();
        model_last = N - 1;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    function automatic bit all_empty();
        for (int ch = 0; ch < N; ch++) if (in_q[ch].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic wait_drain(input int maxc, input string name);
        int c;
        c = 0;
        while ((!all_empty() || exp_q.size() != 0) && c < maxc) begin
            step(1);
            c++;
        end
        check(name, c < maxc, 1);
        step(3);
    endtask

    // FIFO side: sample pops mid-cycle, retire them at the edge, apply random backpressure.
    initial begin
        logic [N-1:0] p;
        int           c;
        forever begin
            @(negedge clk);
            p = in_pop;
            if (p != '0) begin
                check("pop_onehot", $onehot0(p), 1);
                c = 0;
                for (int i = 0; i < N; i++) if (p[i]) c = i;
                check("pop_nonempty", in_q[c].size() != 0, 1);
                if (in_q[c].size() != 0)
                    check("pop_af_clear", out_almost_full[dest_of(in_q[c][0])], 0);
                pop_cyc.push_back(cyc);
                pop_ch.push_back(c);
            end
            @(posedge clk);
            #1;
            if (reset && p != '0) begin
                for (int i = 0; i < N; i++) if (p[i] && in_q[i].size() != 0) void'(in_q[i].pop_front());
            end
            cyc++;
            if (rand_af)
                for (int i = 0; i < N; i++) out_almost_full[i] = ($urandom_range(0, 3) == 0);
            refresh();
        end
    end

    // Monitor: every push must follow a pop and match the next expected word.
    initial begin
        logic [DW-1:0] e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                prev_pop = 1'b0;
            end else begin
                check("push_follows_pop", out_push != '0, prev_pop);
                if (out_push != '0) begin
                    check("push_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("push_data", out_data, e);
                        check("push_dest", out_push, 4'b1 << dest_of(e));
                    end
                end
                prev_pop = (in_pop != '0);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int L;
        int c;
        int t2_offs [6];
        int t3_offs [4];
        int t3_ch [4];
        t2_offs = '{1, 2, 3, 4, 6, 7};
        t3_offs = '{1, 2, 5, 6};
        t3_ch   = '{0, 0, 2, 2};

        reset = 1'b0;
        in_empty = '1;
        in_data = '0;
        out_almost_full = '0;
        refresh();

        // 1: reset values, then idle with everything empty
        step(1);
        check("rst_in_pop", in_pop, 0);
        check("rst_out_push", out_push, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_grant", grant, 3);
        step(1);
        reset = 1'b1;
        repeat (4) begin
            @(negedge clk);
            check("idle_in_pop", in_pop, 0);
            check("idle_out_push", out_push, 0);
            check("idle_busy", busy, 0);
            check("idle_grant", grant, 3);
        end
        step(1);

        // 2: one channel, 6 words: quantum of 4, one bubble, then 2
        for (int i = 0; i < 6; i++) in_q[0].push_back(12'h096);
        build_expected();
        pop_cyc.delete();
        pop_ch.delete();
        L = cyc;
        refresh();
        wait_drain(100, "t2_drain");
        check("t2_pop_count", pop_cyc.size(), 6);
        if (pop_cyc.size() == 6)
            for (int i = 0; i < 6; i++) check("t2_pop_offset", pop_cyc[i] - L, t2_offs[i]);

        // 3: two channels, 2 words each, all routed to dest 2
        apply_reset();
        for (int i = 0; i < 2; i++) begin
            in_q[0].push_back(12'h8F0);
            in_q[2].push_back(12'h8F0);
        end
        build_expected();
        pop_cyc.delete();
        pop_ch.delete();
        L = cyc;
        refresh();
        wait_drain(100, "t3_drain");
        check("t3_pop_count", pop_cyc.size(), 4);
        if (pop_cyc.size() == 4)
            for (int i = 0; i < 4; i++) begin
                check("t3_pop_offset", pop_cyc[i] - L, t3_offs[i]);
                check("t3_pop_channel", pop_ch[i], t3_ch[i]);
            end

        // 4: stall on almost_full of dest 3, grant held
        in_q[1].push_back(12'hD1E);
        out_almost_full = 4'b1000;
        build_expected();
        refresh();
        step(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_pop", in_pop, 0);
            check("t4_stall_busy", busy, 1);
            check("t4_stall_grant", grant, 1);
            step(1);
        end
        out_almost_full = '0;
        @(negedge clk);
        check("t4_pop_after_release", in_pop, 4'b0010);
        @(negedge clk);
        check("t4_push_dest3", out_push, 4'b1000);
        check("t4_push_data", out_data, 12'hD1E);
        wait_drain(50, "t4_drain");

        // 5: reset mid-burst on ch3 at count 2
        for (int i = 0; i < 4; i++) in_q[3].push_back(DW'($urandom));
        build_expected();
        pop_cyc.delete();
        refresh();
        c = 0;
        while (pop_cyc.size() < 2 && c < 30) begin
            step(1);
            c++;
        end
        check("t5_reach_count2", pop_cyc.size(), 2);
        check("t5_push_pending", out_push != '0, 1);
        #1;
        reset = 1'b0;
        #1;
        check("t5_rst_out_push", out_push, 0);
        check("t5_rst_out_data", out_data, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_in_pop", in_pop, 0);
        check("t5_rst_grant", grant, 3);
        exp_q.delete();
        model_last = N - 1;
        for (int i = 0; i < 3; i++) in_q[0].push_back(DW'($urandom));
        refresh();
        step(2);
        build_expected();
        pop_ch.delete();
        reset = 1'b1;
        wait_drain(100, "t5_drain");
        check("t5_first_after_reset", (pop_ch.size() != 0) ? pop_ch[0] : -1, 0);
        check("t5_pops_after_reset", pop_ch.size(), 5);

        // Random batches with random backpressure
        rand_af = 1'b1;
        for (int b = 0; b < 6; b++) begin
            for (int ch = 0; ch < N; ch++) begin
                int n;
                n = $urandom_range(0, 9);
                for (int j = 0; j < n; j++) in_q[ch].push_back(DW'($urandom));
            end
            build_expected();
            refresh();
            wait_drain(800, "rand_drain");
        end
        rand_af = 1'b0;
        step(1);
        out_almost_full = '0;
        step(2);

`ifdef ARB_STATS_EN
        // 6: 10 words to dest 1 with a 3-cycle mid-burst stall
        apply_reset();
        for (int i = 0; i < 10; i++) in_q[2].push_back({2'b01, 10'($urandom)});
        build_expected();
        pop_cyc.delete();
        refresh();
        c = 0;
        while (pop_cyc.size() < 1 && c < 30) begin
            step(1);
            c++;
        end
        out_almost_full = 4'b0010;
        step(3);
        out_almost_full = '0;
        wait_drain(100, "t6_drain");
        check("t6_words_dest0", stats_words[0*CW +: CW], 0);
        check("t6_words_dest1", stats_words[1*CW +: CW], 10);
        check("t6_words_dest2", stats_words[2*CW +: CW], 0);
        check("t6_stall", stats_stall, 3);
`endif

        check("final_scoreboard_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
